// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU (A) and load (B) writeback,
// registered WE/Rw/busW, and a per-register pending scoreboard for RAW stalls.
module rf_write_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          a_valid,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] Ra,
    input  logic [AW-1:0] Rb,
    output logic          pendA,
    output logic          pendB,
    output logic          WE,
    output logic [AW-1:0] Rw,
    output logic [DW-1:0] busW
);

    localparam int NREG = 1 << AW;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_req_t;

    gnt_e            last_gnt_q, last_gnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   rw_q, rw_d;
    logic [DW-1:0]   busw_q, busw_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            grant_a, grant_b, hs;
    wr_req_t         wr_req;
    logic            iss_set;

    // Readies are gated by RSTn so nothing is consumed while the block is in reset.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (RSTn) begin
            if (a_valid && b_valid) begin
                grant_a = (last_gnt_q == GNT_B);
                grant_b = !grant_a;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign hs      = grant_a | grant_b;

    always_comb begin
        wr_req = '0;
        if (grant_a) begin
            wr_req.rd   = a_rd;
            wr_req.data = a_data;
        end else if (grant_b) begin
            wr_req.rd   = b_rd;
            wr_req.data = b_data;
        end
    end

    assign iss_set = iss_valid && !(ZERO_PROTECT && (iss_rd == '0));

    always_comb begin
        last_gnt_d = last_gnt_q;
        we_d       = 1'b0;
        rw_d       = rw_q;
        busw_d     = busw_q;
        pending_d  = pending_q;

        if (grant_a) begin
            last_gnt_d = GNT_A;
        end else if (grant_b) begin
            last_gnt_d = GNT_B;
        end

        // An r0 write still consumes the request and retires its reservation.
        if (hs) begin
            we_d                 = !(ZERO_PROTECT && (wr_req.rd == '0));
            rw_d                 = wr_req.rd;
            busw_d               = wr_req.data;
            pending_d[wr_req.rd] = 1'b0;
        end

        // Applied after the clear: a fresh reservation outlives the older write.
        if (iss_set) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            last_gnt_q <= GNT_B;
            we_q       <= 1'b0;
            rw_q       <= '0;
            busw_q     <= '0;
            pending_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
            pending_q  <= pending_d;
        end
    end

    assign WE    = we_q;
    assign Rw    = rw_q;
    assign busW  = busw_q;
    assign pendA = pending_q[Ra];
    assign pendB = pending_q[Rb];

endmodule
